// File: rtl/prio_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : prio_arbiter
//  Description : Registered N-way priority arbiter with active-low requests
//                and an active-low one-hot grant. Supports fixed or
//                round-robin priority, grant holding until done/withdrawal,
//                and an optional hold-time limit with a timeout pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 15,
  localparam int W       = $clog2(N),
  localparam int HW      = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         en_b,
  input  logic         rr_mode,
  input  logic [N-1:0] req_b,
  input  logic         done,
  output logic [N-1:0] gnt_b,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_valid,
  output logic         timeout
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Last count value before the limit forces a release; only meaningful
  // when the limit is enabled.
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t         state_q;
  logic [N-1:0]   gnt_b_q;
  logic [W-1:0]   gnt_idx_q;
  logic           gnt_valid_q;
  logic           timeout_q;
  logic [W-1:0]   ptr_q;
  logic [HW-1:0]  hcnt_q;

  logic [W-1:0]   start_d;
  logic [W-1:0]   cand_d;
  logic [W-1:0]   win_idx_d;
  logic           win_found_d;

  logic           exit_en_d;
  logic           exit_done_d;
  logic           exit_wdraw_d;
  logic           exit_limit_d;
  logic           exit_any_d;

  // Fixed mode starts the descending search at the top index; round-robin
  // starts one below the last winner. W-bit arithmetic gives the wrap for free.
  assign start_d = rr_mode ? (ptr_q - W'(1)) : {W{1'b1}};

  // Priority encoder: first requesting index found while descending from start.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int k = 0; k < N; k++) begin
      cand_d = start_d - W'(k);
      if (!win_found_d && !req_b[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
  end

  assign exit_en_d    = en_b;
  assign exit_done_d  = done;
  assign exit_wdraw_d = req_b[gnt_idx_q];
  assign exit_limit_d = (MAX_HOLD != 0) && (hcnt_q == HOLD_LAST);
  assign exit_any_d   = exit_en_d | exit_done_d | exit_wdraw_d | exit_limit_d;

  // Arbitration FSM with registered grant, index, valid and timeout outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      gnt_b_q     <= '1;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr_q       <= '0;
      hcnt_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!en_b && win_found_d) begin
            state_q     <= BUSY;
            gnt_idx_q   <= win_idx_d;
            gnt_b_q     <= ~(N'(1) << win_idx_d);
            gnt_valid_q <= 1'b1;
            hcnt_q      <= '0;
            ptr_q       <= win_idx_d;
          end
        end
        BUSY: begin
          if (exit_any_d) begin
            state_q     <= IDLE;
            gnt_b_q     <= '1;
            gnt_valid_q <= 1'b0;
            // Only a pure limit expiry is reported as a timeout.
            timeout_q   <= exit_limit_d & ~exit_en_d & ~exit_done_d & ~exit_wdraw_d;
          end else if (hcnt_q != {HW{1'b1}}) begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          gnt_b_q     <= '1;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_b     = gnt_b_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: doc/prio_arbiter.md
# prio_arbiter

Registered N-way priority arbiter. It combines a parametrised priority encoder, which selects a winner from active-low requests, with a parametrised decoder, which drives an active-low one-hot grant. It adds grant holding, a fixed or round-robin priority mode, and a hold-time limit. It sits between N requesters and one shared resource and generalises the 8-to-3 encode / 3-to-8 decode path into a stateful, handshaked block.

## Interface
- N, default 8: number of requesters; power of two, 2..64. W = $clog2(N) is derived.
- MAX_HOLD, default 15: maximum grant length in cycles, 1..255; 0 disables the limit. Counter width is $clog2(MAX_HOLD+1), minimum 1.

- clk  in  1  system clock; all state updates on the posedge.
- rst_b  in  1  asynchronous, active-low reset.
- en_b  in  1  active-low enable. When high, no grant is issued and any held grant is released.
- rr_mode  in  1  priority mode: 0 = fixed, 1 = round-robin. Sampled only at a grant decision.
- req_b  in  N  active-low requests; req_b[i]=0 means requester i is requesting.
- done  in  1  current grantee releases the resource. Sampled only in BUSY.
- gnt_b  out  N  registered active-low one-hot grant; all ones when there is no grant.
- gnt_idx  out  W  binary index of the current grantee; holds its last value when there is no grant.
- gnt_valid  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse when a grant is forcibly released by the MAX_HOLD limit.

## Operation
- States: IDLE, BUSY. Internal registers: last-grant pointer ptr (W bits) and hold counter hcnt.
- Reset (asserted asynchronously, any state): state=IDLE, gnt_b=all ones, gnt_idx=0, gnt_valid=0, timeout=0, ptr=0, hcnt=0.
- IDLE, with en_b=0 and at least one req_b bit low:
  - Select winner w and go to BUSY.
  - Set gnt_idx=w, gnt_b = ~(1<<w), gnt_valid=1, hcnt=0, ptr=w.
- IDLE, otherwise: stay in IDLE with outputs unchanged; gnt_b stays all ones.
- Fixed mode winner: highest requesting index.
- Round-robin mode winner: search starts at index (ptr-1) mod N and descends, wrapping from 0 to N-1. The first requesting index wins. After ptr=0 the search starts at N-1. Because ptr resets to 0, the first round-robin decision after reset matches fixed mode.
- BUSY is left at the next posedge if any of the following holds, checked in priority order:
  - en_b=1
  - done=1
  - req_b[gnt_idx]=1 (requester withdrew)
  - MAX_HOLD≠0 and hcnt==MAX_HOLD-1
- On leaving BUSY: state=IDLE, gnt_b=all ones, gnt_valid=0, gnt_idx held.
- timeout=1 for exactly one cycle only when the exit cause is the MAX_HOLD limit alone. It stays 0 if en_b, done or withdrawal is also true on that edge.
- BUSY without an exit condition: hcnt increments, saturating at its maximum. Grant outputs are unchanged.
- Changes to req_b and rr_mode during BUSY have no effect on the current grant.

## Timing
- Grant latency: a request sampled low in IDLE at edge k produces gnt_b/gnt_valid valid after edge k (registered, 1 cycle).
- Release: an exit condition sampled at edge k clears the grant after edge k.
- Re-arbitration happens at edge k+1, so there is always at least one IDLE cycle between consecutive grants.
- A grant lasts at least 1 cycle. With the limit enabled it lasts at most MAX_HOLD cycles.
- done asserted in the same cycle the grant appears is honoured at the next edge, giving a 1-cycle grant.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-grant: outputs go to reset values immediately, asynchronously. The first arbitration occurs at the first posedge after rst_b deasserts.

## Test plan
All scenarios use N=8, MAX_HOLD=4.
- Reset: rst_b=0 asserted mid-BUSY between edges -> gnt_b=8'hFF, gnt_valid=0, gnt_idx=0 without waiting for a clock edge.
- Fixed mode: rr_mode=0, req_b=8'b1010_1110 -> one edge later gnt_idx=6, gnt_b=8'b1011_1111, gnt_valid=1.
- Round-robin wrap: rr_mode=1, req_b=8'h00, done pulsed once per grant -> grant sequence 7,6,5,4,3,2,1,0,7 with one IDLE cycle between grants.
- Hold limit: req_b=8'hFE held, done=0 -> gnt_valid high for exactly 4 cycles, timeout=1 for one cycle, then one IDLE cycle, then index 0 is granted again.
- Enable: en_b=1 in IDLE with req_b=8'h00 -> no grant. en_b=1 during BUSY -> grant drops at the next edge and timeout stays 0.
- Withdrawal: while index 3 is granted, req_b[3] goes to 1 -> gnt_b=8'hFF after the next edge. With req_b[5]=0 still asserted and rr_mode=1, index 2 wins only if requesting; otherwise the search wraps and index 5 is granted.
